// File: rtl/mult_operand_feeder.sv
// rtl/mult_operand_feeder.sv - serial operand loader for the 4-bit AND-array multiplier stage
// Serialises a parallel A/B pair MSB first into the stage's shift buffer and indexed B port.
module mult_operand_feeder #(
   parameter int unsigned IDLE_GAP = 0
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       in_valid_i,
   output logic       in_ready_o,
   input  logic [3:0] in_a_i,
   input  logic [3:0] in_b_i,
   output logic       a_o,
   output logic       b_o,
   output logic [2:0] ctrl_in_b_o,
   output logic       loaded_o,
   output logic [7:0] op_cnt_o
);
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_VALID = 2'd2
   } state_e;

   localparam logic [3:0] GAP_LOAD  = 4'(IDLE_GAP);
   localparam logic [2:0] CTRL_HOLD = 3'b100;

   state_e     state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   logic [3:0] in_a_q, in_a_d;
   logic [3:0] in_b_q, in_b_d;
   logic [3:0] gap_q, gap_d;
   logic       a_q, a_d;
   logic       b_q, b_d;
   logic [2:0] ctrl_q, ctrl_d;
   logic       loaded_q, loaded_d;
   logic [7:0] op_cnt_q, op_cnt_d;
   logic       accept;
   logic [1:0] idx_d;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      in_a_d     = in_a_q;
      in_b_d     = in_b_q;
      gap_d      = gap_q;
      in_ready_o = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            in_ready_o = (gap_q == 4'd0);
            if (gap_q != 4'd0) gap_d = gap_q - 4'd1;
         end
         S_SHIFT: begin
            if (cnt_q == 2'd3) state_d = S_VALID;
            else               cnt_d   = cnt_q + 2'd1;
         end
         S_VALID: begin
            in_ready_o = (IDLE_GAP == 0);
            state_d    = S_IDLE;
            gap_d      = GAP_LOAD;
         end
         default: state_d = S_IDLE;
      endcase
      accept = in_valid_i && in_ready_o;
      if (accept) begin
         state_d = S_SHIFT;
         cnt_d   = 2'd0;
         in_a_d  = in_a_i;
         in_b_d  = in_b_i;
      end
   end

   // Outputs are registered, so they are derived from the state being entered.
   always_comb begin
      idx_d    = ~cnt_d;
      a_d      = 1'b0;
      b_d      = 1'b0;
      ctrl_d   = CTRL_HOLD;
      loaded_d = 1'b0;
      unique case (state_d)
         S_SHIFT: begin
            a_d    = in_a_d[idx_d];
            b_d    = in_b_d[idx_d];
            ctrl_d = {1'b0, idx_d};
         end
         S_VALID: loaded_d = 1'b1;
         default: ;
      endcase
      op_cnt_d = op_cnt_q + {7'd0, state_q == S_VALID};
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= S_IDLE;
         cnt_q    <= 2'd0;
         in_a_q   <= 4'd0;
         in_b_q   <= 4'd0;
         gap_q    <= 4'd0;
         a_q      <= 1'b0;
         b_q      <= 1'b0;
         ctrl_q   <= CTRL_HOLD;
         loaded_q <= 1'b0;
         op_cnt_q <= 8'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         in_a_q   <= in_a_d;
         in_b_q   <= in_b_d;
         gap_q    <= gap_d;
         a_q      <= a_d;
         b_q      <= b_d;
         ctrl_q   <= ctrl_d;
         loaded_q <= loaded_d;
         op_cnt_q <= op_cnt_d;
      end
   end

   assign a_o         = a_q;
   assign b_o         = b_q;
   assign ctrl_in_b_o = ctrl_q;
   assign loaded_o    = loaded_q;
   assign op_cnt_o    = op_cnt_q;

endmodule

// File: tb/tb_mult_operand_feeder.sv
// tb/tb_mult_operand_feeder.sv - randomized and directed bench for mult_operand_feeder
// Instance 0 runs with IDLE_GAP=0, instance 1 with IDLE_GAP=3; both share the input drive.
module tb_mult_operand_feeder;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [3:0] in_a = 4'd0;
   logic [3:0] in_b = 4'd0;
   logic       rdy[2];
   logic       a[2];
   logic       b[2];
   logic       loaded[2];
   logic [2:0] ctrl[2];
   logic [7:0] opc[2];

   int compared = 0;
   int errors   = 0;
   int cyc      = 0;

   // Behavioural model: cycle of the last accept and the operands it captured.
   int         t_acc[2];
   int         mops[2];
   logic [3:0] ma[2];
   logic [3:0] mb[2];

   // Model of the multiplier stage's A shift buffer and indexed B buffer.
   logic [3:0] abuf[2];
   logic [3:0] bbuf[2];

   always #5 clk = ~clk;

   mult_operand_feeder #(.IDLE_GAP(0)) dut0 (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy[0]),
      .in_a_i(in_a), .in_b_i(in_b), .a_o(a[0]), .b_o(b[0]), .ctrl_in_b_o(ctrl[0]),
      .loaded_o(loaded[0]), .op_cnt_o(opc[0])
   );

   mult_operand_feeder #(.IDLE_GAP(3)) dut3 (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy[1]),
      .in_a_i(in_a), .in_b_i(in_b), .a_o(a[1]), .b_o(b[1]), .ctrl_in_b_o(ctrl[1]),
      .loaded_o(loaded[1]), .op_cnt_o(opc[1])
   );

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         abuf[k] <= {abuf[k][2:0], a[k]};
         if (!ctrl[k][2]) bbuf[k][ctrl[k][1:0]] <= b[k];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic reset_dut();
      in_valid = 1'b0;
      rst_n    = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 2; k++) begin
         t_acc[k] = -100000;
         mops[k]  = 0;
      end
   endtask

   function automatic bit m_ready(int k);
      int d = cyc - t_acc[k];
      int g = (k == 1) ? 3 : 0;
      return (g == 0) ? (d >= 5) : (d >= 6 + g);
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      for (int c = 0; c < 5; c++) begin
         in_valid = 1'($urandom);
         in_a     = 4'($urandom);
         in_b     = 4'($urandom);
         tick();
         for (int k = 0; k < 2; k++) begin
            compared++;
            if (rdy[k] !== 1'b1 || ctrl[k] !== 3'b100 || a[k] !== 1'b0 ||
                loaded[k] !== 1'b0 || opc[k] !== 8'd0) begin
               errors++;
               $display("FAIL reset k%0d: rdy=%b ctrl=%b a=%b loaded=%b opc=%0d want 1 100 0 0 0",
                        k, rdy[k], ctrl[k], a[k], loaded[k], opc[k]);
            end
         end
      end
      reset_dut();
   endtask

   task automatic test_single_op();
      logic [3:0] ea = 4'b1011;
      reset_dut();
      in_valid = 1'b1;
      in_a     = 4'b1011;
      in_b     = 4'b0110;
      compared++;
      if (rdy[0] !== 1'b1) begin
         errors++;
         $display("FAIL single_ready_idle: got %b want 1", rdy[0]);
      end
      for (int c = 1; c <= 6; c++) begin
         tick();
         in_valid = 1'b0;
         in_a     = 4'($urandom);
         in_b     = 4'($urandom);
         if (c <= 4) begin
            compared++;
            if (a[0] !== ea[4-c] || ctrl[0] !== 3'(4 - c)) begin
               errors++;
               $display("FAIL single_shift c%0d: a=%b ctrl=%b want a=%b ctrl=%b",
                        c, a[0], ctrl[0], ea[4-c], 3'(4 - c));
            end
         end
         compared++;
         if (loaded[0] !== (c == 5)) begin
            errors++;
            $display("FAIL single_loaded c%0d: got %b want %b", c, loaded[0], c == 5);
         end
         if (c == 5) begin
            compared++;
            if ((abuf[0] & bbuf[0]) !== 4'b0010) begin
               errors++;
               $display("FAIL single_product: got %b want 0010", abuf[0] & bbuf[0]);
            end
         end
         if (c == 6) begin
            compared++;
            if (opc[0] !== 8'd1) begin
               errors++;
               $display("FAIL single_opcnt: got %0d want 1", opc[0]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      reset_dut();
      in_valid = 1'b1;
      in_a     = 4'b1111;
      in_b     = 4'b1111;
      for (int c = 1; c <= 10; c++) begin
         tick();
         if (c == 1) begin
            in_a = 4'b0101;
            in_b = 4'b1100;
         end
         if (c == 6) in_valid = 1'b0;
         compared++;
         if (loaded[0] !== (c == 5 || c == 10) || rdy[0] !== (c == 5 || c == 10)) begin
            errors++;
            $display("FAIL b2b c%0d: loaded=%b ready=%b want %b", c, loaded[0], rdy[0],
                     c == 5 || c == 10);
         end
         if (c == 5 || c == 10) begin
            compared++;
            if ((abuf[0] & bbuf[0]) !== ((c == 5) ? 4'b1111 : 4'b0100)) begin
               errors++;
               $display("FAIL b2b_product c%0d: got %b want %b", c, abuf[0] & bbuf[0],
                        (c == 5) ? 4'b1111 : 4'b0100);
            end
         end
      end
   endtask

   task automatic test_idle_gap();
      reset_dut();
      in_valid = 1'b1;
      in_a     = 4'b0011;
      in_b     = 4'b0101;
      for (int c = 1; c <= 14; c++) begin
         tick();
         if (c == 10) in_valid = 1'b0;
         if (c <= 9) begin
            compared++;
            if (rdy[1] !== (c == 9)) begin
               errors++;
               $display("FAIL gap_ready c%0d: got %b want %b", c, rdy[1], c == 9);
            end
         end
         compared++;
         if (loaded[1] !== (c == 5 || c == 14)) begin
            errors++;
            $display("FAIL gap_loaded c%0d: got %b want %b", c, loaded[1], c == 5 || c == 14);
         end
      end
   endtask

   task automatic test_reset_mid_op();
      reset_dut();
      in_valid = 1'b1;
      in_a     = 4'b1111;
      in_b     = 4'b1111;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      compared++;
      if (a[0] !== 1'b1 || ctrl[0] !== 3'b001) begin
         errors++;
         $display("FAIL midrst_pre: a=%b ctrl=%b want 1 001", a[0], ctrl[0]);
      end
      #2 rst_n = 1'b0;
      #1;
      compared++;
      if (a[0] !== 1'b0 || ctrl[0] !== 3'b100 || loaded[0] !== 1'b0 ||
          rdy[0] !== 1'b1 || opc[0] !== 8'd0) begin
         errors++;
         $display("FAIL midrst_async: a=%b ctrl=%b loaded=%b rdy=%b opc=%0d want 0 100 0 1 0",
                  a[0], ctrl[0], loaded[0], rdy[0], opc[0]);
      end
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         tick();
         compared++;
         if (loaded[0] !== 1'b0 || opc[0] !== 8'd0 || ctrl[0] !== 3'b100) begin
            errors++;
            $display("FAIL midrst_after c%0d: loaded=%b opc=%0d ctrl=%b want 0 0 100",
                     c, loaded[0], opc[0], ctrl[0]);
         end
      end
   endtask

   task automatic run_traffic(input int n_ops, input int max_cycles, input int pct);
      int d;
      for (int i = 0; i < max_cycles && mops[0] < n_ops; i++) begin
         tick();
         for (int k = 0; k < 2; k++) begin
            d = cyc - t_acc[k];
            compared++;
            if (rdy[k] !== m_ready(k) || loaded[k] !== (d == 5) || opc[k] !== 8'(mops[k]) ||
                a[k] !== ((d >= 1 && d <= 4) ? ma[k][4-d] : 1'b0) ||
                ctrl[k] !== ((d >= 1 && d <= 4) ? 3'(4 - d) : 3'b100)) begin
               errors++;
               $display("FAIL traffic k%0d d%0d: rdy=%b loaded=%b opc=%0d a=%b ctrl=%b want rdy=%b opc=%0d",
                        k, d, rdy[k], loaded[k], opc[k], a[k], ctrl[k], m_ready(k), 8'(mops[k]));
            end
            if (d >= 1 && d <= 4) begin
               compared++;
               if (b[k] !== mb[k][4-d]) begin
                  errors++;
                  $display("FAIL traffic_b k%0d d%0d: got %b want %b", k, d, b[k], mb[k][4-d]);
               end
            end
            if (d == 5) begin
               compared++;
               if ((abuf[k] & bbuf[k]) !== (ma[k] & mb[k])) begin
                  errors++;
                  $display("FAIL traffic_product k%0d: got %b want %b", k, abuf[k] & bbuf[k],
                           ma[k] & mb[k]);
               end
               mops[k]++;
            end
         end
         in_valid = ($urandom_range(0, 99) < pct);
         in_a     = 4'($urandom);
         in_b     = 4'($urandom);
         for (int k = 0; k < 2; k++) begin
            if (in_valid && m_ready(k)) begin
               t_acc[k] = cyc;
               ma[k]    = in_a;
               mb[k]    = in_b;
            end
         end
      end
      compared++;
      if (mops[0] < n_ops) begin
         errors++;
         $display("FAIL traffic_timeout: got %0d ops want %0d", mops[0], n_ops);
      end
   endtask

   task automatic test_random_traffic();
      reset_dut();
      run_traffic(40, 800, 50);
   endtask

   task automatic test_wrap();
      reset_dut();
      run_traffic(256, 4000, 70);
      tick();
      compared++;
      if (opc[0] !== 8'd0) begin
         errors++;
         $display("FAIL wrap_opcnt: got %0d want 0", opc[0]);
      end
   endtask

   initial begin
      test_reset();
      test_single_op();
      test_back_to_back();
      test_idle_gap();
      test_reset_mid_op();
      test_random_traffic();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
      $finish;
   end
endmodule
